// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer write-port arbiter.
package fb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        OWNED
    } arb_state_t;

    localparam int unsigned N_REQ_DEFAULT = 3;

    localparam int unsigned REQ_FILL   = 0;
    localparam int unsigned REQ_LINE   = 1;
    localparam int unsigned REQ_SYMBOL = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last_owner+1.
module rr_picker #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IdxW  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  last_owner_i,
    output logic             valid_o,
    output logic [IdxW-1:0]  winner_o
);

    int              cand;
    logic [IdxW-1:0] cand_idx;

    // Walk from the farthest candidate down to the nearest so the nearest one wins.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            cand     = (int'(last_owner_i) + k) % int'(N_REQ);
            cand_idx = IdxW'(cand);
            if (req_i[cand_idx]) begin
                valid_o  = 1'b1;
                winner_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the single frame-buffer write port shared by the drawing engines.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    output logic [N_REQ-1:0]            grant_o,
    input  logic [N_REQ-1:0]            req_write_enable_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_write_addr_i,
    input  logic [N_REQ-1:0]            req_write_data_i,
    input  logic                        hold_i,
    output logic                        busy_o,
    output logic                        fb_write_enable_o,
    output logic [ADDR_WIDTH-1:0]       fb_write_addr_o,
    output logic                        fb_write_data_o,
    output logic                        collision_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t            state_q, state_d;
    logic [IdxW-1:0]       last_owner_q, last_owner_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic                  fb_data_q, fb_data_d;
    logic                  collision_q, collision_d;

    logic                  pick_valid;
    logic [IdxW-1:0]       pick_winner;
    logic                  owner_holds;
    logic [N_REQ-1:0]      fwd;

    rr_picker #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_rr_picker (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign owner_holds = |(req_i & grant_q);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        unique case (state_q)
            IDLE: begin
                if (!hold_i && pick_valid) begin
                    state_d              = OWNED;
                    grant_d              = '0;
                    grant_d[pick_winner] = 1'b1;
                    last_owner_d         = pick_winner;
                end
            end
            OWNED: begin
                if (!owner_holds) begin
                    // Owner's req is already low, so any valid pick is another requester.
                    if (!hold_i && pick_valid) begin
                        grant_d              = '0;
                        grant_d[pick_winner] = 1'b1;
                        last_owner_d         = pick_winner;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    always_comb begin
        fwd         = grant_q & req_write_enable_i;
        fb_we_d     = |fwd;
        fb_addr_d   = '0;
        fb_data_d   = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (fwd[i]) begin
                fb_addr_d = fb_addr_d | req_write_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                fb_data_d = fb_data_d | req_write_data_i[i];
            end
        end
        collision_d = collision_q | (|(req_write_enable_i & ~grant_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= IdxW'(N_REQ - 1);
            grant_q      <= '0;
            busy_q       <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            collision_q  <= collision_d;
        end
    end

    assign grant_o           = grant_q;
    assign busy_o            = busy_q;
    assign fb_write_enable_o = fb_we_q;
    assign fb_write_addr_o   = fb_addr_q;
    assign fb_write_data_o   = fb_data_q;
    assign collision_o       = collision_q;

endmodule
